mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port unified 16-bit memory between three requesters:
//  instruction fetch (IF), controller load/store (LS) and debug port (DBG).
//  Sits between the multi-cycle controller/datapath and the memory macro.
//  Fixed priority DBG > LS > IF, with a starvation override that protects IF.
//  Handles configurable read latency and returns read data to the owner.
// PARAMETERS
//  ADDR_W      16  address width
//  DATA_W      16  data width
//  MEM_LAT     1   memory read latency in cycles, legal 1..4
//  STARVE_MAX  4   consecutive IF losses before IF is forced top priority
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  if_req     in   1       IF read request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  IF read address
//  if_gnt     out  1       one-cycle grant pulse to IF
//  if_rvalid  out  1       one-cycle pulse: rdata holds IF read data
//  ls_req     in   1       LS request; held with ls_we/addr/wdata until ls_gnt
//  ls_we      in   1       1 = store, 0 = load
//  ls_addr    in   ADDR_W  LS address
//  ls_wdata   in   DATA_W  LS store data
//  ls_gnt     out  1       one-cycle grant pulse to LS
//  ls_rvalid  out  1       one-cycle pulse: rdata holds LS load data
//  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid: as LS, for DBG
//  rdata      out  DATA_W  registered read data, shared by all requesters
//  mem_en     out  1       memory access strobe, high only in issue cycle
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after issue
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all gnt/rvalid, mem_en, mem_we = 0;
//    mem_addr, mem_wdata, rdata = 0; starve_cnt = 0; in-flight read dropped,
//    no rvalid emitted after reset release.
//  - States: IDLE, WAIT_RD.
//  - IDLE: if any req, pick winner (see priority). In the same cycle: winner gnt=1,
//    mem_en=1, mem_we/addr/wdata = winner's inputs (combinational issue).
//    Write -> stay IDLE (next grant possible next cycle, no rvalid).
//    Read -> WAIT_RD, latch owner, load lat_cnt = MEM_LAT.
//  - WAIT_RD: decrement lat_cnt each cycle; no grants, mem_en=0. When lat_cnt
//    reaches 0 (cycle T+MEM_LAT after issue at T): capture mem_rdata
//    into rdata, go IDLE. Owner's rvalid pulses at T+MEM_LAT+1 with rdata valid;
//    a new grant may occur in that same cycle.
//  - Read-to-read throughput: one access every MEM_LAT+1 cycles.
//  - rdata holds last read value until next capture; not cleared on writes.
//  - Priority: DBG > LS > IF, except when starve_cnt == STARVE_MAX -> IF first.
//  - starve_cnt: +1 (saturating at STARVE_MAX) on each grant to LS/DBG while
//    if_req=1; cleared on if_gnt; unchanged otherwise.
//  - A req dropped in a cycle is not granted in that cycle; requesters must not
//    drop req before gnt (protocol violation, behaviour undefined).
//  - At most one gnt and at most one rvalid high per cycle; never gnt in WAIT_RD.
//  - Widths: lat_cnt is 3 bits, starve_cnt is $clog2(STARVE_MAX+1) bits.
// STRUCTURE
//  - Shared include header: owner encoding OWN_NONE=2'd0, OWN_IF=2'd1,
//    OWN_LS=2'd2, OWN_DBG=2'd3; state encoding ST_IDLE, ST_WAIT_RD.
//  - Sub-module mem_arb_pick: combinational priority pick with starvation
//    override (inputs: 3 reqs, starve flag; output: one-hot grant).
//  - Top: FSM, lat_cnt, starve_cnt, owner register, rdata register, output muxes.
// TESTING
//  1 Reset mid-read: IF read issued, rst_n=0 at T+1 -> all outputs 0,
//    no if_rvalid after release.
//  2 Lone IF read, MEM_LAT=2, addr 16'h0040, mem returns 16'hBEEF ->
//    if_gnt at T, if_rvalid=1 and rdata=16'hBEEF at T+3.
//  3 LS and IF requesting together at IDLE: ls_gnt first. LS store 16'h1234
//    to 16'h0100 -> mem_we=1 for one cycle only. if_gnt next cycle. No rvalid.
//  4 DBG, LS, IF all requesting reads -> grant order DBG, LS, IF,
//    each MEM_LAT+1 cycles apart.
//  5 LS re-requests continuously with IF pending, STARVE_MAX=4 -> 4 ls_gnt,
//    then if_gnt; starve_cnt back to 0.
//  6 Back-to-back: IF read completes; LS store waiting -> ls_gnt in the same cycle as if_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared definitions for the unified-memory port arbiter.
//               Contains the owner encoding, the FSM state type, the
//               requester bit positions used in one-hot grant vectors, and
//               owner/one-hot conversion helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Owner of the read currently in flight.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_LS   = 2'd2;
  localparam logic [1:0] OWN_DBG  = 2'd3;

  // Bit positions inside every {dbg, ls, if} one-hot vector.
  localparam int REQ_IF  = 0;
  localparam int REQ_LS  = 1;
  localparam int REQ_DBG = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WAIT_RD = 1'b1
  } state_t;

  function automatic logic [1:0] onehot_owner(input logic [2:0] oh);
    logic [1:0] own;
    own = OWN_NONE;
    if (oh[REQ_DBG])     own = OWN_DBG;
    else if (oh[REQ_LS]) own = OWN_LS;
    else if (oh[REQ_IF]) own = OWN_IF;
    return own;
  endfunction

  function automatic logic [2:0] owner_onehot(input logic [1:0] own);
    logic [2:0] oh;
    oh = 3'b000;
    case (own)
      OWN_IF:  oh[REQ_IF]  = 1'b1;
      OWN_LS:  oh[REQ_LS]  = 1'b1;
      OWN_DBG: oh[REQ_DBG] = 1'b1;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational fixed-priority picker, DBG > LS > IF, with a
//               starvation override that puts IF first when asserted.
// Ports       : req_i    [2:0] requests {dbg, ls, if}
//               starve_i       IF starvation flag
//               gnt_o    [2:0] one-hot winner {dbg, ls, if}, 0 if no request
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick (
  input  logic [2:0] req_i,
  input  logic       starve_i,
  output logic [2:0] gnt_o
);
  import mem_port_arbiter_pkg::*;

  always_comb begin
    gnt_o = 3'b000;
    if (starve_i && req_i[REQ_IF]) gnt_o[REQ_IF]  = 1'b1;
    else if (req_i[REQ_DBG])       gnt_o[REQ_DBG] = 1'b1;
    else if (req_i[REQ_LS])        gnt_o[REQ_LS]  = 1'b1;
    else if (req_i[REQ_IF])        gnt_o[REQ_IF]  = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-port memory between instruction fetch (IF),
//               load/store (LS) and debug (DBG). Issues the winning access
//               combinationally in IDLE, waits MEM_LAT cycles for read data,
//               registers it into rdata and pulses the owner's rvalid.
// Ports       : clk, rst_n                      clock, async active-low reset
//               if_req/if_addr -> if_gnt         IF read request / grant
//               if_rvalid                        IF read data valid on rdata
//               ls_req/we/addr/wdata -> ls_gnt   LS request / grant
//               ls_rvalid                        LS load data valid on rdata
//               dbg_* (as LS)                    debug port
//               rdata                            registered shared read data
//               mem_en/we/addr/wdata, mem_rdata  memory macro interface
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_port_arbiter_pkg::*;

  localparam int         SC_W     = $clog2(STARVE_MAX + 1);
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t            state_q, state_d;
  logic [2:0]        lat_q, lat_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [1:0]        owner_q, owner_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        rvalid_q, rvalid_d;

  logic [2:0]        pick_gnt;
  logic [2:0]        gnt;
  logic              starve_sat;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  assign starve_sat = (starve_q == SC_W'(STARVE_MAX));

  mem_arb_pick u_pick (
    .req_i    ({dbg_req, ls_req, if_req}),
    .starve_i (starve_sat),
    .gnt_o    (pick_gnt)
  );

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    rdata_d     = rdata_q;
    rvalid_d    = 3'b000;
    gnt         = 3'b000;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (|pick_gnt) begin
          gnt = pick_gnt;
          if (pick_gnt[REQ_DBG]) begin
            issue_we    = dbg_we;
            issue_addr  = dbg_addr;
            issue_wdata = dbg_wdata;
          end else if (pick_gnt[REQ_LS]) begin
            issue_we    = ls_we;
            issue_addr  = ls_addr;
            issue_wdata = ls_wdata;
          end else begin
            issue_addr  = if_addr;
          end
          // Writes complete in the issue cycle; only reads occupy the port.
          if (!issue_we) begin
            state_d = ST_WAIT_RD;
            lat_d   = LAT_INIT;
            owner_d = onehot_owner(pick_gnt);
          end
          // Only a loss while IF is actually waiting counts as starvation.
          if (pick_gnt[REQ_IF]) begin
            starve_d = '0;
          end else if (if_req && !starve_sat) begin
            starve_d = starve_q + SC_W'(1);
          end
        end
      end
      ST_WAIT_RD: begin
        lat_d = lat_q - 3'd1;
        // lat_q==1 is cycle T+MEM_LAT: memory data is valid now.
        if (lat_q == 3'd1) begin
          rdata_d  = mem_rdata;
          rvalid_d = owner_onehot(owner_q);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      lat_q    <= 3'd0;
      starve_q <= '0;
      owner_q  <= OWN_NONE;
      rdata_q  <= '0;
      rvalid_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign if_gnt     = gnt[REQ_IF];
  assign ls_gnt     = gnt[REQ_LS];
  assign dbg_gnt    = gnt[REQ_DBG];
  assign if_rvalid  = rvalid_q[REQ_IF];
  assign ls_rvalid  = rvalid_q[REQ_LS];
  assign dbg_rvalid = rvalid_q[REQ_DBG];
  assign rdata      = rdata_q;
  assign mem_en     = |gnt;
  assign mem_we     = issue_we;
  assign mem_addr   = issue_addr;
  assign mem_wdata  = issue_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A timeline model
//               (port busy-until cycle, return cycle, IF loss count, shadow
//               memory) predicts every output each cycle; directed scenarios
//               are followed by a randomized traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              if_req, ls_req, ls_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] if_addr, ls_addr, dbg_addr;
  logic [DATA_W-1:0] ls_wdata, dbg_wdata;
  logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- memory macro model (4K words, MEM_LAT read pipe) -------
  function automatic logic [15:0] init_val(input logic [11:0] a);
    if (a == 12'h040) return 16'hBEEF;
    return {a, 4'h0} ^ 16'h5A5A;
  endfunction

  logic [15:0] dev_mem [0:4095];
  bit          dev_wr  [0:4095];
  logic [15:0] pipe    [0:MEM_LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      dev_mem[mem_addr[11:0]] <= mem_wdata;
      dev_wr[mem_addr[11:0]]  <= 1'b1;
    end
    if (mem_en && !mem_we)
      pipe[0] <= dev_wr[mem_addr[11:0]] ? dev_mem[mem_addr[11:0]] : init_val(mem_addr[11:0]);
    else
      pipe[0] <= 16'($urandom);
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  // ---------------- reference model state ----------------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc, busy_until, ret_cyc, ret_who, starve;
  logic [15:0] ret_data, last_rdata;
  logic [15:0] ref_mem [0:4095];
  bit          rand_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_if(input logic [15:0] a);
    if_req = 1'b1; if_addr = a;
  endtask
  task automatic set_ls(input logic we, input logic [15:0] a, input logic [15:0] d);
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d;
  endtask
  task automatic set_dbg(input logic we, input logic [15:0] a, input logic [15:0] d);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
  endtask

  // One clock cycle: predict and check, advance the model, then drop the
  // winner's request (and optionally raise random new ones).
  task automatic step(output logic [2:0] g, output logic [2:0] rv);
    int          win;
    logic        we;
    logic [15:0] a, wd;
    logic [2:0]  eg, ev;
    #1;
    win = 0; we = 1'b0; a = '0; wd = '0;
    if (cyc >= busy_until) begin
      if (if_req && starve >= STARVE_MAX) win = 1;
      else if (dbg_req)                    win = 3;
      else if (ls_req)                     win = 2;
      else if (if_req)                     win = 1;
    end
    case (win)
      1: begin we = 1'b0;   a = if_addr;              end
      2: begin we = ls_we;  a = ls_addr;  wd = ls_wdata;  end
      3: begin we = dbg_we; a = dbg_addr; wd = dbg_wdata; end
      default: ;
    endcase
    eg = 3'b000; if (win != 0) eg[win-1] = 1'b1;
    ev = 3'b000;
    if (cyc == ret_cyc) begin ev[ret_who-1] = 1'b1; last_rdata = ret_data; end
    g  = {dbg_gnt, ls_gnt, if_gnt};
    rv = {dbg_rvalid, ls_rvalid, if_rvalid};
    chk("gnt", g, eg);
    chk("rvalid", rv, ev);
    chk("rdata", rdata, last_rdata);
    chk("mem_en", mem_en, win != 0);
    chk("mem_we", mem_we, (win != 0) && we);
    if (win != 0) begin
      chk("mem_addr", mem_addr, a);
      if (we) chk("mem_wdata", mem_wdata, wd);
    end
    if (win != 0) begin
      if (we) begin
        ref_mem[a[11:0]] = wd;
        busy_until = cyc + 1;
      end else begin
        busy_until = cyc + MEM_LAT + 1;
        ret_cyc    = busy_until;
        ret_who    = win;
        ret_data   = ref_mem[a[11:0]];
      end
      if (win == 1)       starve = 0;
      else if (if_req)    starve = (starve < STARVE_MAX) ? starve + 1 : starve;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (win == 1) if_req  = 1'b0;
    if (win == 2) ls_req  = 1'b0;
    if (win == 3) dbg_req = 1'b0;
    if (rand_mode) begin
      if (!if_req && $urandom_range(0, 2) == 0)  set_if(16'($urandom_range(0, 4095)));
      if (!ls_req && $urandom_range(0, 2) == 0)
        set_ls(1'($urandom_range(0, 1)), 16'($urandom_range(0, 4095)), 16'($urandom));
      if (!dbg_req && $urandom_range(0, 5) == 0)
        set_dbg(1'($urandom_range(0, 1)), 16'($urandom_range(0, 4095)), 16'($urandom));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; dbg_req = 1'b0;
    #1;
    chk("rst_gnt", {dbg_gnt, ls_gnt, if_gnt}, 3'b000);
    chk("rst_rvalid", {dbg_rvalid, ls_rvalid, if_rvalid}, 3'b000);
    chk("rst_mem_en_we", {mem_en, mem_we}, 2'b00);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    busy_until = cyc; ret_cyc = -1; ret_who = 0; starve = 0; last_rdata = '0;
  endtask

  initial begin
    logic [2:0] g, rv;
    int nls, nif;
    int gc [0:2];
    rand_mode = 1'b0;
    cyc = 0; busy_until = 0; ret_cyc = -1; ret_who = 0; starve = 0;
    ret_data = '0; last_rdata = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = '0;
    if_addr = '0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    @(negedge clk);
    do_reset();

    // 1: reset while an IF read is in flight -> no rvalid afterwards
    set_if(16'h0123);
    step(g, rv);
    do_reset();
    for (int i = 0; i < MEM_LAT + 3; i++) step(g, rv);

    // 2: lone IF read of 0x0040 returns BEEF at T+MEM_LAT+1
    do_reset();
    set_if(16'h0040);
    step(g, rv);
    chk("t2_if_gnt_at_T", g, 3'b001);
    for (int i = 0; i < MEM_LAT; i++) step(g, rv);
    #1;
    chk("t2_if_rvalid", if_rvalid, 1'b1);
    chk("t2_rdata", rdata, 16'hBEEF);
    step(g, rv);
    step(g, rv);

    // 3: LS store beats IF; one-cycle write; IF next cycle; store readable
    do_reset();
    set_ls(1'b1, 16'h0100, 16'h1234);
    set_if(16'h0200);
    step(g, rv);
    chk("t3_ls_first", g, 3'b010);
    #1;
    chk("t3_mem_we_one_cycle", mem_we, 1'b0);
    step(g, rv);
    chk("t3_if_next", g, 3'b001);
    for (int i = 0; i < MEM_LAT + 1; i++) step(g, rv);
    set_dbg(1'b0, 16'h0100, 16'h0000);
    for (int i = 0; i < MEM_LAT + 1; i++) step(g, rv);
    #1;
    chk("t3_readback", rdata, 16'h1234);
    step(g, rv);

    // 4: three simultaneous reads -> DBG, LS, IF spaced MEM_LAT+1 apart
    do_reset();
    set_dbg(1'b0, 16'h0011, 16'h0);
    set_ls(1'b0, 16'h0022, 16'h0);
    set_if(16'h0033);
    gc[0] = -1; gc[1] = -1; gc[2] = -1;
    for (int i = 0; i < 3 * (MEM_LAT + 1) + 2; i++) begin
      step(g, rv);
      for (int k = 0; k < 3; k++) if (g[k]) gc[k] = i;
    end
    chk("t4_dbg_cycle", gc[2], 0);
    chk("t4_ls_cycle", gc[1], MEM_LAT + 1);
    chk("t4_if_cycle", gc[0], 2 * (MEM_LAT + 1));

    // 5: LS hammering with IF pending -> STARVE_MAX LS grants, then IF (twice)
    do_reset();
    set_if(16'h0400);
    set_ls(1'b1, 16'h0500, 16'h0001);
    nls = 0; nif = 0;
    for (int i = 0; i < 2 * (STARVE_MAX + MEM_LAT + 1) + 2; i++) begin
      step(g, rv);
      if (g[1]) nls++;
      if (g[0]) begin
        chk("t5_ls_wins_before_if", nls, STARVE_MAX);
        nls = 0; nif++;
        set_if(16'($urandom_range(0, 4095)));
      end
      set_ls(1'b1, 16'($urandom_range(0, 4095)), 16'($urandom));
    end
    chk("t5_if_grants", nif, 2);

    // 6: LS store granted in the same cycle as the IF rvalid
    do_reset();
    set_if(16'h0600);
    step(g, rv);
    set_ls(1'b1, 16'h0700, 16'hA5A5);
    for (int i = 0; i < MEM_LAT; i++) step(g, rv);
    step(g, rv);
    chk("t6_gnt_with_rvalid", {g[1], rv[0]}, 2'b11);
    step(g, rv);

    // Randomized traffic
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) step(g, rv);
    rand_mode = 1'b0;
    for (int i = 0; i < 3 * (MEM_LAT + 1) * 3; i++) step(g, rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
